// File: rtl/pipe_retire_monitor.sv
// Writeback-side observer for the pipelined Y86-64 core: shadow register file of
// committed results, saturating performance counters and a run/halt/fault monitor.
module pipe_retire_monitor #(
  parameter int CNT_W = 32,
  parameter int WDOG  = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       W_icode,
  input  logic [1:0]       W_stat,
  input  logic [3:0]       W_dstE,
  input  logic [63:0]      W_valE,
  input  logic [3:0]       W_dstM,
  input  logic [63:0]      W_valM,
  input  logic             F_stall,
  input  logic [3:0]       rd_sel,
  output logic [63:0]      rd_data,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             done,
  output logic             fault,
  output logic [1:0]       fault_code
);

  localparam int WD_W = $clog2(WDOG + 1);

  localparam logic [3:0] NO_REG    = 4'hF;
  localparam logic [3:0] ICODE_NOP = 4'h1;

  localparam logic [1:0] STAT_AOK = 2'b00;
  localparam logic [1:0] STAT_HLT = 2'b01;
  localparam logic [1:0] STAT_ADR = 2'b10;
  localparam logic [1:0] STAT_INS = 2'b11;

  localparam logic [1:0] CODE_NONE    = 2'b00;
  localparam logic [1:0] CODE_TIMEOUT = 2'b01;
  localparam logic [1:0] CODE_ADR     = 2'b10;
  localparam logic [1:0] CODE_INS     = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_HALTED,
    ST_FAULT
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       fault_code_q, fault_code_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic [63:0]      regs_q [15];
  logic [63:0]      regs_d [15];

  logic in_run;
  logic is_instr;
  logic wdog_expire;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + CNT_W'(1);
  endfunction

  assign in_run      = (state_q == ST_RUN);
  assign is_instr    = (W_icode != ICODE_NOP);
  // Expiry is the edge on which the idle count would reach WDOG.
  assign wdog_expire = !is_instr && (wdog_q == WD_W'(WDOG - 1));

  always_comb begin
    state_d      = state_q;
    fault_code_d = fault_code_q;
    if (in_run) begin
      case (W_stat)
        STAT_HLT: state_d = ST_HALTED;
        STAT_ADR: begin
          state_d      = ST_FAULT;
          fault_code_d = CODE_ADR;
        end
        STAT_INS: begin
          state_d      = ST_FAULT;
          fault_code_d = CODE_INS;
        end
        default: begin
          if (wdog_expire) begin
            state_d      = ST_FAULT;
            fault_code_d = CODE_TIMEOUT;
          end
        end
      endcase
    end
  end

  always_comb begin
    cycle_cnt_d   = cycle_cnt_q;
    retired_cnt_d = retired_cnt_q;
    stall_cnt_d   = stall_cnt_q;
    wdog_d        = wdog_q;
    if (in_run) begin
      cycle_cnt_d = sat_inc(cycle_cnt_q);
      if (F_stall) stall_cnt_d = sat_inc(stall_cnt_q);
      // A halting instruction retires; a faulting one does not.
      if (is_instr && (W_stat == STAT_AOK || W_stat == STAT_HLT))
        retired_cnt_d = sat_inc(retired_cnt_q);
      wdog_d = is_instr ? '0 : wdog_q + WD_W'(1);
    end
  end

  // M write is applied last so it wins when both ports target the same register.
  always_comb begin
    regs_d = regs_q;
    if (in_run && W_stat == STAT_AOK) begin
      if (W_dstE != NO_REG) regs_d[W_dstE] = W_valE;
      if (W_dstM != NO_REG) regs_d[W_dstM] = W_valM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      fault_code_q  <= CODE_NONE;
      cycle_cnt_q   <= '0;
      retired_cnt_q <= '0;
      stall_cnt_q   <= '0;
      wdog_q        <= '0;
      for (int i = 0; i < 15; i++) regs_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      fault_code_q  <= fault_code_d;
      cycle_cnt_q   <= cycle_cnt_d;
      retired_cnt_q <= retired_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      wdog_q        <= wdog_d;
      for (int i = 0; i < 15; i++) regs_q[i] <= regs_d[i];
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_sel != NO_REG) rd_data = regs_q[rd_sel];
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign retired_cnt = retired_cnt_q;
  assign stall_cnt   = stall_cnt_q;
  assign done        = (state_q == ST_HALTED);
  assign fault       = (state_q == ST_FAULT);
  assign fault_code  = fault_code_q;

endmodule

// File: doc/pipe_retire_monitor.md
# pipe_retire_monitor

Writeback-side observer for the Y86-64 pipelined core. It sits directly downstream of the `y86wrapPipe` W-stage outputs and consumes the signals the wrapper exposes each cycle. From these it keeps a shadow register file of architecturally committed values, counts cycles, retired instructions and fetch stalls, and runs a run/halt/fault state machine with a no-retire watchdog. Testbenches use it to end simulation and to check final register state without probing core internals.

## Interface
- `CNT_W`, 32: width of every performance counter.
- `WDOG`, 64: consecutive cycles without a retirement that trigger a timeout fault; must be ≥ 2.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `W_icode` in 4: icode in the W stage. 4'h1 (nop/bubble) is not a retirement.
- `W_stat` in 2: W status. 00 AOK, 01 HLT, 10 ADR, 11 INS.
- `W_dstE` in 4: E destination; 4'hF means none.
- `W_valE` in 64: E write value.
- `W_dstM` in 4: M destination; 4'hF means none.
- `W_valM` in 64: M write value.
- `F_stall` in 1: fetch stall indicator.
- `rd_sel` in 4: shadow register read select.
- `rd_data` out 64: shadow register `rd_sel`, combinational from registered state; returns 0 for `rd_sel`=4'hF.
- `cycle_cnt` out CNT_W: cycles spent in RUN.
- `retired_cnt` out CNT_W: retired instructions.
- `stall_cnt` out CNT_W: RUN cycles with `F_stall`=1.
- `done` out 1: state is HALTED.
- `fault` out 1: state is FAULT.
- `fault_code` out 2: 00 none, 01 timeout, 10 ADR, 11 INS.

## Operation
- States: RUN (reset state), HALTED, FAULT. HALTED and FAULT are terminal and are left only through reset.
- A retirement is a cycle in RUN where `W_icode` ≠ 4'h1.
- Transitions from RUN, evaluated on each edge in priority order:
  - `W_stat`=HLT → HALTED.
  - `W_stat`=ADR → FAULT, code 10.
  - `W_stat`=INS → FAULT, code 11.
  - Watchdog reaches WDOG → FAULT, code 01.
- A `W_stat` event on the same edge as watchdog expiry takes precedence over the timeout.
- Shadow file: 15 × 64-bit entries, indices 0–14.
  - Writes occur only in RUN with `W_stat`=AOK.
  - `W_dstE` ≠ F writes `W_valE`; `W_dstM` ≠ F writes `W_valM`.
  - If `W_dstE`=`W_dstM` ≠ F, `W_valM` is the value written.
  - A faulting or halting W instruction writes nothing.
- Counters:
  - `cycle_cnt` +1 every RUN cycle.
  - `retired_cnt` +1 on each retirement. A HLT instruction counts; ADR and INS instructions do not.
  - `stall_cnt` +1 on every RUN cycle with `F_stall`=1.
  - All counters saturate at all-ones and freeze in terminal states.
- Watchdog:
  - Internal counter of width ⌈log2(WDOG+1)⌉.
  - Cleared on a retirement, otherwise +1 in RUN.
  - Expiry is the edge at which the count would reach WDOG.

## Timing
- Reset (asynchronous, while `rst_n`=0):
  - state RUN.
  - All counters, the watchdog and all shadow entries 0.
  - `done`=0, `fault`=0, `fault_code`=00, `rd_data`=0.
- Inputs are sampled at the rising edge. Effects (register write, counter increment, state change) are visible after that edge: 1-cycle latency.
- `rd_data` has zero latency from `rd_sel`. A same-edge write becomes visible after the edge; there is no write-through.
- `done`/`fault` assert in the cycle after the HLT/ADR/INS W-cycle is sampled.
- The final `cycle_cnt` includes the HLT cycle.
- Reset deassertion mid-program restarts everything from the reset values. No state survives.
- Inputs are ignored while in a terminal state.

## Test plan
- Reset, then W sequence irmovq(3) dstE=0 valE=5; nop; OPq(6) dstE=0 valE=7; halt(0) with HLT. Expect `rd_data`[0]=7, `retired_cnt`=3, `cycle_cnt`=4, and `done` high exactly one cycle after the halt edge.
- One mrmovq-style W cycle with dstE=4, valE=8, dstM=4, valM=9. Expect `rd_data`[4]=9.
- ADR on an instruction with dstE=2, valE=1. Expect `fault`=1, `fault_code`=10, reg2 unchanged, and `retired_cnt` unchanged by that instruction.
- WDOG=4 with only nops. Expect FAULT code 01 after the 4th RUN cycle. Separately, an HLT on the expiry edge gives HALTED, not FAULT.
- `F_stall`=1 for 3 cycles during RUN gives `stall_cnt`=3. Assert `rst_n`=0 mid-run: all outputs return to 0 immediately, without waiting for a clock edge.
- CNT_W=4 with 20 RUN cycles: `cycle_cnt` holds at 15.
